sort_stream_ctrl: RTL and testbench

//  Host-side driver/collector for the linear systolic sort array of PE cells. Accepts a batch of
//  up to DEPTH words on a valid/ready stream, feeds them into the head PE (Xin, mode=1), flushes,

---
 rtl/sort_stream_ctrl.sv | 123 ++++++++++++
 tb/tb_sort_stream_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sort_stream_ctrl.sv
// sort_stream_ctrl: loads a batch into a systolic sort array, flushes it, then drains it as a descending stream
module sort_stream_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             sat_flag,
  output logic             busy,
  output logic             arr_mode,
  output logic             arr_shift_read,
  output logic [WIDTH-1:0] arr_xin,
  output logic [WIDTH-1:0] arr_zin,
  input  logic [WIDTH-1:0] arr_zout
);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, FLUSH = 2'd2, DRAIN = 2'd3;
  localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MAX_M1 = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [1:0] state_q, state_d, occ_q, occ_d;
  logic [CW-1:0] cnt_q, cnt_d, pc_q, pc_d, ci_q, ci_d;
  logic [WIDTH:0] buf_q [2];
  logic [WIDTH:0] buf_d [2];
  logic in_ready_q, in_ready_d, sat_q, sat_d, mode_q, mode_d, shift_q, shift_d, cap_q, cap_d;
  logic [WIDTH-1:0] xin_q, xin_d;
  logic accept, pop, keep, wr_idx;
  always_comb begin
    accept = in_ready_q & in_valid;
    pop = (occ_q != 2'd0) & out_ready;
    keep = cap_q & (ci_q >= FULL - cnt_q);
    wr_idx = occ_q[1] | (occ_q[0] & ~pop);
    state_d = state_q;
    cnt_d = cnt_q;
    pc_d = pc_q;
    ci_d = ci_q;
    xin_d = MAX;
    mode_d = 1'b0;
    shift_d = 1'b0;
    cap_d = shift_q;
    sat_d = accept & (in_data == MAX);
    case (state_q)
      IDLE, LOAD: begin
        mode_d = accept | (state_q == LOAD);
        pc_d = '0;
        ci_d = '0;
        if (accept) begin
          xin_d = (in_data == MAX) ? MAX_M1 : in_data;
          cnt_d = cnt_q + CW'(1);
          state_d = (in_last || cnt_d == FULL) ? FLUSH : LOAD;
        end
      end
      FLUSH: begin
        mode_d = 1'b1;
        pc_d = (pc_q == FULL - CW'(1)) ? '0 : pc_q + CW'(1);
        state_d = (pc_q == FULL - CW'(1)) ? DRAIN : FLUSH;
      end
      default: begin
        // shifts in flight are counted as if every one will land in the buffer, so it can never overflow
        shift_d = (pc_q != FULL) && (3'(occ_q) + 3'(shift_q) + 3'(cap_q) < 3'd2);
        pc_d = pc_q + CW'(shift_d);
        ci_d = ci_q + CW'(cap_q);
        if (ci_q == FULL && occ_q == 2'd0) begin
          state_d = IDLE;
          cnt_d = '0;
        end
      end
    endcase
    buf_d = buf_q;
    if (pop) buf_d[0] = buf_q[1];
    if (keep) buf_d[wr_idx] = {ci_q == FULL - CW'(1), arr_zout};
    occ_d = occ_q + 2'(keep) - 2'(pop);
    in_ready_d = (state_d == IDLE) || (state_d == LOAD);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      occ_q <= '0;
      cnt_q <= '0;
      pc_q <= '0;
      ci_q <= '0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      in_ready_q <= 1'b0;
      sat_q <= 1'b0;
      mode_q <= 1'b0;
      shift_q <= 1'b0;
      cap_q <= 1'b0;
      xin_q <= MAX;
    end else begin
      state_q <= state_d;
      occ_q <= occ_d;
      cnt_q <= cnt_d;
      pc_q <= pc_d;
      ci_q <= ci_d;
      buf_q <= buf_d;
      in_ready_q <= in_ready_d;
      sat_q <= sat_d;
      mode_q <= mode_d;
      shift_q <= shift_d;
      cap_q <= cap_d;
      xin_q <= xin_d;
    end
  end
  assign in_ready = in_ready_q;
  assign out_valid = occ_q != 2'd0;
  assign out_data = buf_q[0][WIDTH-1:0];
  assign out_last = buf_q[0][WIDTH];
  assign sat_flag = sat_q;
  assign busy = state_q != IDLE;
  assign arr_mode = mode_q;
  assign arr_shift_read = shift_q;
  assign arr_xin = xin_q;
  assign arr_zin = MAX;
endmodule

// File: tb/tb_sort_stream_ctrl.sv
// tb_sort_stream_ctrl: random/directed batches through the controller and a behavioural PE array, scoreboarded against a sort model
module tb_sort_stream_ctrl;
  localparam int W = 32;
  localparam int D = 8;
  localparam logic [W-1:0] MAX = {W{1'b1}};
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [W-1:0] in_data = '0;
  logic in_ready, out_valid, out_last, sat_flag, busy, arr_mode, arr_shift_read;
  logic [W-1:0] out_data, arr_xin, arr_zin, arr_zout;
  int checks = 0, passes = 0, rdy_mode = 0;
  logic [W-1:0] exp_d [$];
  logic exp_l [$];
  logic [W-1:0] stream [$];
  logic sat_pend = 1'b0;

  sort_stream_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .sat_flag(sat_flag), .busy(busy), .arr_mode(arr_mode),
    .arr_shift_read(arr_shift_read), .arr_xin(arr_xin), .arr_zin(arr_zin), .arr_zout(arr_zout)
  );

  always #5 clk = ~clk;

  // behavioural PE chain: insert keeps min and forwards max, shift-read moves stored values toward the tail
  logic [W-1:0] st [D];
  logic [W-1:0] xo [D];
  logic [W-1:0] xa [D];
  logic [W-1:0] za [D];
  logic [W-1:0] zo;
  always_comb begin
    xa[0] = arr_xin;
    za[0] = arr_zin;
    for (int i = 1; i < D; i++) begin
      xa[i] = xo[i-1];
      za[i] = st[i-1];
    end
  end
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < D; i++) begin
        st[i] <= MAX;
        xo[i] <= MAX;
      end
      zo <= MAX;
    end else if (arr_mode) begin
      for (int i = 0; i < D; i++) begin
        st[i] <= (xa[i] < st[i]) ? xa[i] : st[i];
        xo[i] <= (xa[i] < st[i]) ? st[i] : xa[i];
      end
    end else if (arr_shift_read) begin
      zo <= st[D-1];
      for (int i = 0; i < D; i++) st[i] <= za[i];
    end
  end
  assign arr_zout = zo;

  task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) $display("FAIL %s: got %0h expected %0h", nm, a, e);
    else passes++;
  endtask

  // reference: split the stream into batches (in_last or DEPTH words), clamp MAX, sort descending
  task automatic model_stream();
    logic [W-1:0] cur [$];
    foreach (stream[i]) begin
      cur.push_back(stream[i] == MAX ? MAX - 1 : stream[i]);
      if (i == stream.size() - 1 || cur.size() == D) begin
        cur.rsort();
        foreach (cur[j]) begin
          exp_d.push_back(cur[j]);
          exp_l.push_back(j == cur.size() - 1);
        end
        cur.delete();
      end
    end
  endtask

  task automatic send_word(logic [W-1:0] d, logic l);
    int n = 0;
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    while (!in_ready && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 3000) begin
      checks++;
      $display("FAIL in_ready timeout: got 0 expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic send_stream(int gap);
    model_stream();
    foreach (stream[i]) begin
      if ($urandom_range(99) < gap) repeat ($urandom_range(1, 2)) begin
        @(posedge clk); #1;
      end
      send_word(stream[i], i == stream.size() - 1);
    end
  endtask

  task automatic wait_idle(string nm);
    int n = 0;
    while (busy && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, " idle"}, 64'(busy), 64'(0));
    chk({nm, " drained"}, 64'(exp_d.size()), 64'(0));
  endtask

  task automatic check_reset_vals();
    chk("rst in_ready", 64'(in_ready), 64'(0));
    chk("rst out_valid", 64'(out_valid), 64'(0));
    chk("rst out_last", 64'(out_last), 64'(0));
    chk("rst out_data", 64'(out_data), 64'(0));
    chk("rst sat_flag", 64'(sat_flag), 64'(0));
    chk("rst busy", 64'(busy), 64'(0));
    chk("rst arr_mode", 64'(arr_mode), 64'(0));
    chk("rst arr_shift_read", 64'(arr_shift_read), 64'(0));
    chk("rst arr_xin", 64'(arr_xin), 64'(MAX));
    chk("rst arr_zin", 64'(arr_zin), 64'(MAX));
  endtask

  initial begin
    int ph = 0;
    forever begin
      @(posedge clk); #1;
      ph = (ph + 1) % 3;
      out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? (ph == 0) : 1'($urandom_range(1));
    end
  end

  initial forever begin
    logic [W-1:0] ed;
    logic el;
    @(negedge clk);
    if (reset) begin
      exp_d.delete();
      exp_l.delete();
      sat_pend = 1'b0;
    end else begin
      if (sat_pend || sat_flag) chk("sat_flag", 64'(sat_flag), 64'(sat_pend));
      sat_pend = in_valid && in_ready && in_data == MAX;
      if (out_valid && out_ready) begin
        if (exp_d.size() == 0) begin
          checks++;
          $display("FAIL extra output: got %0h expected none", out_data);
        end else begin
          ed = exp_d.pop_front();
          el = exp_l.pop_front();
          chk("out_data", 64'(out_data), 64'(ed));
          chk("out_last", 64'(out_last), 64'(el));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    reset = 1'b0;
    @(posedge clk); #1;
    chk("in_ready after reset", 64'(in_ready), 64'(1));
    stream = '{32'd10, 32'd24, 32'd6, 32'd7, 32'd3, 32'd1, 32'd100, 32'd6};
    send_stream(0);
    wait_idle("T1");
    stream = '{32'd9, 32'd6, 32'd5, 32'd3};
    send_stream(0);
    wait_idle("T2");
    rdy_mode = 1;
    stream = '{32'd10, 32'd24, 32'd6, 32'd7, 32'd3, 32'd1, 32'd100, 32'd6};
    send_stream(0);
    wait_idle("T3");
    rdy_mode = 0;
    stream = '{32'd42};
    send_stream(0);
    wait_idle("T4a");
    stream = '{32'd5, 32'd7};
    send_stream(0);
    wait_idle("T4b");
    stream = '{MAX, 32'd17, 32'd3};
    send_stream(0);
    wait_idle("T5");
    rdy_mode = 2;
    stream.delete();
    for (int i = 0; i < 11; i++) stream.push_back($urandom_range(1000));
    send_stream(20);
    wait_idle("autoclose");
    for (int k = 0; k < 25; k++) begin
      stream.delete();
      for (int i = 0; i < int'($urandom_range(1, 12)); i++) begin
        n = int'($urandom_range(9));
        stream.push_back(n == 0 ? MAX : (n < 4 ? W'($urandom_range(15)) : $urandom));
      end
      rdy_mode = int'($urandom_range(2));
      send_stream(25);
      wait_idle("random");
    end
    rdy_mode = 2;
    stream.delete();
    for (int i = 0; i < D; i++) stream.push_back($urandom);
    send_stream(0);
    n = 0;
    while (!out_valid && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("T6 reached drain", 64'(out_valid), 64'(1));
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_vals();
    reset = 1'b0;
    @(posedge clk); #1;
    rdy_mode = 0;
    stream = '{32'd10, 32'd24, 32'd6, 32'd7, 32'd3, 32'd1, 32'd100, 32'd6};
    send_stream(0);
    wait_idle("T6");
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
